// File: rtl/adder_serial_chunk_amisha_pkg.sv
// Shared definitions for the chunk-serial wide adder: FSM state encoding and
// the width of the chunk index register.
package adder_serial_chunk_amisha_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // At least one bit so a single-chunk build still has a legal index register.
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/adder_serial_chunk_amisha_adder.sv
// Combinational N-bit adder with carry-in; the one adder reused for every
// chunk of the wide operation.
module chunk_adder_cin_amisha #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign sum   = total[N-1:0];
  assign cout  = total[N];

endmodule

// File: rtl/adder_serial_chunk_amisha.sv
// Multi-cycle W = N*K bit adder: one N-bit chunk per clock, LSB chunk first,
// carry chained through a register; result published only when complete.
module adder_serial_chunk_amisha
  import adder_serial_chunk_amisha_pkg::*;
#(
  parameter  int N = 4,
  parameter  int K = 4,
  localparam int W = N * K
) (
  input  logic         clk_amisha,
  input  logic         reset_amisha,
  input  logic         start_amisha,
  input  logic [W-1:0] a_amisha,
  input  logic [W-1:0] b_amisha,
  output logic         ready_amisha,
  output logic         done_tick_amisha,
  output logic [W-1:0] sum_amisha,
  output logic         cout_amisha
);

  localparam int IW = idx_width(K);

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic [W-1:0]    res_d;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic            cout_q;
  logic            done_q;
  logic            ready_q;
  logic [IW-1:0]   idx_q;

  logic [N-1:0]    chunk_sum;
  logic            chunk_cout;

  // Operands shift right each op cycle, so the active chunk is always bits [N-1:0].
  chunk_adder_cin_amisha #(.N(N)) u_chunk_adder (
    .a    (a_q[N-1:0]),
    .b    (b_q[N-1:0]),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // New chunk enters at the top; after K shifts the full sum is aligned.
  assign res_d = (res_q >> N) | (W'(chunk_sum) << (W - N));

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_amisha) begin
            a_q     <= a_amisha;
            b_q     <= b_amisha;
            carry_q <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          a_q     <= a_q >> N;
          b_q     <= b_q >> N;
          res_q   <= res_d;
          carry_q <= chunk_cout;
          if (idx_q == IW'(K - 1)) begin
            // Publish the finished result in one step so sum never shows a partial value.
            sum_q   <= res_d;
            cout_q  <= chunk_cout;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_amisha     = ready_q;
  assign done_tick_amisha = done_q;
  assign sum_amisha       = sum_q;
  assign cout_amisha      = cout_q;

endmodule

// File: tb/tb_adder_serial_chunk_amisha.sv
// Self-checking bench for adder_serial_chunk_amisha: directed cases plus a
// randomised sweep on three parameterisations against plain A+B arithmetic.
module tb_adder_serial_chunk_amisha;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [W-1:0] a, b, sum;
  logic         ready, done, cout;

  logic         start3;
  logic [2:0]   a3, b3, sum3;
  logic         ready3, done3, cout3;

  logic         start8;
  logic [15:0]  a8, b8, sum8;
  logic         ready8, done8, cout8;

  int checks   = 0;
  int failures = 0;

  adder_serial_chunk_amisha #(.N(4), .K(4)) dut (
    .clk_amisha       (clk),
    .reset_amisha     (rst),
    .start_amisha     (start),
    .a_amisha         (a),
    .b_amisha         (b),
    .ready_amisha     (ready),
    .done_tick_amisha (done),
    .sum_amisha       (sum),
    .cout_amisha      (cout)
  );

  adder_serial_chunk_amisha #(.N(3), .K(1)) dut_k1 (
    .clk_amisha       (clk),
    .reset_amisha     (rst),
    .start_amisha     (start3),
    .a_amisha         (a3),
    .b_amisha         (b3),
    .ready_amisha     (ready3),
    .done_tick_amisha (done3),
    .sum_amisha       (sum3),
    .cout_amisha      (cout3)
  );

  adder_serial_chunk_amisha #(.N(8), .K(2)) dut_n8 (
    .clk_amisha       (clk),
    .reset_amisha     (rst),
    .start_amisha     (start8),
    .a_amisha         (a8),
    .b_amisha         (b8),
    .ready_amisha     (ready8),
    .done_tick_amisha (done8),
    .sum_amisha       (sum8),
    .cout_amisha      (cout8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the accept cycle (cycle 0); returns at the negedge
  // of cycle K+2, the first ready cycle, so a caller may restart back-to-back.
  task automatic run_op(input logic [W-1:0] A, input logic [W-1:0] B,
                        input bit ign, input string tag);
    logic [W:0] exp_v;
    logic [W:0] prev;
    logic [W:0] got;
    int         first;
    int         nd;
    bit         held;
    bit         busy_ok;
    exp_v   = {1'b0, A} + {1'b0, B};
    prev    = {cout, sum};
    got     = '0;
    first   = -1;
    nd      = 0;
    held    = 1'b1;
    busy_ok = 1'b1;
    a = A; b = B; start = 1'b1;
    for (int cyc = 1; cyc <= K + 2; cyc++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (first < 0) begin
          first = cyc;
          got   = {cout, sum};
        end
      end else if (first < 0 && {cout, sum} !== prev) begin
        held = 1'b0;
      end
      if (cyc <= K + 1 && ready !== 1'b0) busy_ok = 1'b0;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (ign && (cyc == 2 || cyc == 5)) begin
        start = 1'b1;
        a     = 16'hAAAA;
      end
    end
    chk({tag, "_done_cycle"}, first, K + 1);
    chk({tag, "_done_count"}, nd, 1);
    chk({tag, "_result"}, got, exp_v);
    chk({tag, "_prev_held"}, held, 1'b1);
    chk({tag, "_busy_not_ready"}, busy_ok, 1'b1);
    chk({tag, "_ready_after"}, ready, 1'b1);
    chk({tag, "_result_holds"}, {cout, sum}, exp_v);
  endtask

  initial begin
    int          nd;
    int          lat;
    logic [2:0]  A3, B3;
    logic [15:0] A8, B8;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start3 = 1'b0; a3 = '0; b3 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 1'b1);
    chk("reset_done", done, 1'b0);
    chk("reset_sum", sum, 16'h0000);
    chk("reset_cout", cout, 1'b0);
    chk("reset_ready_k1", ready3, 1'b1);
    chk("reset_ready_n8", ready8, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, "ripple");
    run_op(16'h8000, 16'h8000, 1'b0, "msb_carry");
    run_op(16'h00F0, 16'h0010, 1'b1, "ignore_start");

    // Abort mid-operation with reset: outputs clear and no done_tick follows.
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_ready", ready, 1'b1);
    chk("abort_sum", sum, 16'h0000);
    chk("abort_cout", cout, 1'b0);
    chk("abort_done", done, 1'b0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);

    run_op(16'h1234, 16'h4321, 1'b0, "pre_b2b");
    run_op(16'h7FFF, 16'h0001, 1'b0, "b2b");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, "b2b_hold");

    for (int i = 0; i < 250; i++) begin
      run_op(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0), "rand");
    end

    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      chk("k1_ready", ready3, 1'b1);
      A3 = 3'($urandom); B3 = 3'($urandom);
      a3 = A3; b3 = B3; start3 = 1'b1;
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        start3 = 1'b0;
        a3 = 3'($urandom); b3 = 3'($urandom);
        if (done3) begin
          lat = c;
          break;
        end
      end
      chk("k1_latency", lat, 2);
      chk("k1_result", {cout3, sum3}, {1'b0, A3} + {1'b0, B3});
    end

    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      chk("n8_ready", ready8, 1'b1);
      A8 = 16'($urandom); B8 = 16'($urandom);
      a8 = A8; b8 = B8; start8 = 1'b1;
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        start8 = 1'b0;
        a8 = 16'($urandom); b8 = 16'($urandom);
        if (done8) begin
          lat = c;
          break;
        end
      end
      chk("n8_latency", lat, 3);
      chk("n8_result", {cout8, sum8}, {1'b0, A8} + {1'b0, B8});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
